// File: rtl/s_ram_arbiter.sv
// -----------------------------------------------------------------------------
// s_ram_arbiter
// Shares the single-port S-memory (ramcore) between the RC4 engines
// (0 = init, 1 = shuffle, 2 = decrypt). Access-level round-robin arbitration
// with an ownership lock so one engine can perform an uninterrupted
// read-modify-write sequence (the i/j swap). Read data is returned to the
// engine that issued the read, qualified by a one-hot rvalid pulse RD_LAT
// cycles after the read was accepted.
//
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   req              per-requester access request
//   req_we           per-requester write enable (1 = write, 0 = read)
//   req_lock         keep ownership after this access
//   req_addr         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata        packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt              one-hot grant; access accepted when req[i] & gnt[i]
//   rvalid           one-hot read-return pulse
//   rdata            read data, zero unless some rvalid bit is high
//   owner_valid      a lock is currently held
//   owner_id         index of the lock holder, 0 when no lock
//   ram_addr/ram_wdata/ram_we  to ramcore
//   ram_q            from ramcore
// -----------------------------------------------------------------------------

// Property checker: structural invariants of the arbiter outputs.
module s_ram_arbiter_checker #(
  parameter int N_REQ = 3
) (
  input logic             clk,
  input logic             reset_n,
  input logic [N_REQ-1:0] req,
  input logic [N_REQ-1:0] gnt,
  input logic [N_REQ-1:0] rvalid,
  input logic             owner_valid,
  input logic [1:0]       owner_id
);

  logic [N_REQ-1:0] owner_mask_s;

  // One-hot mask of the current lock holder.
  always_comb begin
    owner_mask_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_mask_s[i] = (owner_id == 2'(i));
    end
  end

  a_gnt_onehot:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!reset_n) (gnt & ~req) == '0);
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rvalid));
  a_owner_id_zero: assert property (@(posedge clk) disable iff (!reset_n)
                                    !owner_valid |-> (owner_id == 2'd0));
  a_lock_blocks:   assert property (@(posedge clk) disable iff (!reset_n)
                                    owner_valid |-> ((gnt & ~owner_mask_s) == '0));

endmodule

module s_ram_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     owner_valid,
  output logic [1:0]               owner_id,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_we,
  input  logic [DATA_W-1:0]        ram_q
);

  // Arbitration state
  logic [1:0]       rr_ptr_r;
  logic             owner_valid_r;
  logic [1:0]       owner_id_r;

  // Read-return pipe: each stage holds the one-hot id of an in-flight read
  // (all zero for a write or an idle cycle), so valid and id travel together.
  logic [N_REQ-1:0] rd_pipe_r [RD_LAT];

  // Combinational arbitration results
  logic [N_REQ-1:0] gnt_s;
  logic [1:0]       gnt_id_s;
  logic             accept_s;
  logic             gnt_we_s;
  logic             gnt_lock_s;
  logic [1:0]       next_ptr_s;

  // Scan bookkeeping
  logic             found_hi_s;
  logic             found_lo_s;
  logic [1:0]       pick_hi_s;
  logic [1:0]       pick_lo_s;
  logic [1:0]       pick_s;

  // Grant selection: owner only while locked, otherwise round-robin from rr_ptr.
  // The wrap-around scan is split into "lowest requester at or above rr_ptr"
  // and "lowest requester overall"; the first wins if it exists.
  always_comb begin
    gnt_s      = '0;
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    pick_hi_s  = 2'd0;
    pick_lo_s  = 2'd0;
    pick_s     = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (2'(i) >= rr_ptr_r)) begin
        found_hi_s = 1'b1;
        pick_hi_s  = 2'(i);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (req[i]) begin
        found_lo_s = 1'b1;
        pick_lo_s  = 2'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    if (found_hi_s) begin
      pick_s = pick_hi_s;
    end else begin
      pick_s = pick_lo_s;
    end
    if (!reset_n) begin
      gnt_s = '0;
    end else if (owner_valid_r) begin
      // Locked: only the owner may be granted; a bubble from the owner grants nobody.
      for (int i = 0; i < N_REQ; i++) begin
        gnt_s[i] = req[i] && (owner_id_r == 2'(i));
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        gnt_s[i] = found_lo_s && (pick_s == 2'(i));
      end
    end
  end

  // Route the granted requester's address, data and controls to ramcore.
  always_comb begin
    gnt_id_s   = 2'd0;
    ram_addr   = '0;
    ram_wdata  = '0;
    gnt_we_s   = 1'b0;
    gnt_lock_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        gnt_id_s   = 2'(i);
        ram_addr   = req_addr[i*ADDR_W +: ADDR_W];
        ram_wdata  = req_wdata[i*DATA_W +: DATA_W];
        gnt_we_s   = req_we[i];
        gnt_lock_s = req_lock[i];
      end else begin
        gnt_id_s = gnt_id_s;
      end
    end
  end

  assign accept_s = |gnt_s;
  assign gnt      = gnt_s;
  assign ram_we   = accept_s & gnt_we_s;

  // Pointer to the requester after the one just served, with wrap.
  always_comb begin
    if (gnt_id_s == 2'(N_REQ - 1)) begin
      next_ptr_s = 2'd0;
    end else begin
      next_ptr_s = gnt_id_s + 2'd1;
    end
  end

  // Round-robin pointer and lock ownership; a locked access freezes the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r      <= 2'd0;
      owner_valid_r <= 1'b0;
      owner_id_r    <= 2'd0;
    end else if (accept_s) begin
      if (gnt_lock_s) begin
        owner_valid_r <= 1'b1;
        owner_id_r    <= gnt_id_s;
        rr_ptr_r      <= rr_ptr_r;
      end else begin
        owner_valid_r <= 1'b0;
        owner_id_r    <= 2'd0;
        rr_ptr_r      <= next_ptr_s;
      end
    end else begin
      rr_ptr_r      <= rr_ptr_r;
      owner_valid_r <= owner_valid_r;
      owner_id_r    <= owner_id_r;
    end
  end

  // Read-return pipe; reset drops every in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        rd_pipe_r[s] <= '0;
      end
    end else begin
      if (accept_s && !gnt_we_s) begin
        rd_pipe_r[0] <= gnt_s;
      end else begin
        rd_pipe_r[0] <= '0;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        rd_pipe_r[s] <= rd_pipe_r[s-1];
      end
    end
  end

  assign rvalid      = rd_pipe_r[RD_LAT-1];
  assign owner_valid = owner_valid_r;
  assign owner_id    = owner_id_r;

  // ram_q is only meaningful in the cycle the matching read emerges from the pipe.
  always_comb begin
    if (|rd_pipe_r[RD_LAT-1]) begin
      rdata = ram_q;
    end else begin
      rdata = '0;
    end
  end

  s_ram_arbiter_checker #(
    .N_REQ (N_REQ)
  ) u_checker (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .gnt         (gnt_s),
    .rvalid      (rvalid),
    .owner_valid (owner_valid_r),
    .owner_id    (owner_id_r)
  );

endmodule

// File: tb/tb_s_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_ram_arbiter
// Directed bench for s_ram_arbiter with a behavioural 256x8 ramcore
// (registered q, new-data read-during-write). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_s_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [2:0]  req_lock;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic        owner_valid;
  logic [1:0]  owner_id;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  logic [7:0]  mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [7:0]  pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ramcore model, with a back door used only while the arbiter is idle.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= ram_we ? ram_wdata : mem[ram_addr];
  end

  s_ram_arbiter #(
    .N_REQ (3), .ADDR_W (8), .DATA_W (8), .RD_LAT (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_q       (ram_q)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    nx();
    pre_we   = 1'b0;
  endtask

  // One cycle of the locked swap by requester 1; requesters 0/2 driven by rq_other.
  task automatic swap_step(input logic r1, input logic we1, input logic lk1,
                           input logic [7:0] a1, input logic [7:0] wd1,
                           input logic [2:0] rq_other, input logic [2:0] e_gnt,
                           input logic e_ov, input logic [1:0] e_oid,
                           input logic [2:0] e_rv, input logic [7:0] e_rd);
    req            = rq_other | {1'b0, r1, 1'b0};
    req_we[1]      = we1;
    req_lock[1]    = lk1;
    req_addr[15:8] = a1;
    req_wdata[15:8] = wd1;
    @(negedge clk);
    check_val("swap_gnt", {29'd0, gnt}, {29'd0, e_gnt});
    check_val("swap_owner_valid", {31'd0, owner_valid}, {31'd0, e_ov});
    check_val("swap_owner_id", {30'd0, owner_id}, {30'd0, e_oid});
    check_val("swap_rvalid", {29'd0, rvalid}, {29'd0, e_rv});
    check_val("swap_rdata", {24'd0, rdata}, {24'd0, e_rd});
    nx();
  endtask

  initial begin
    logic [2:0] e_gnt;
    logic [2:0] e_rv;

    reset_n   = 1'b0;
    req       = 3'b000;
    req_we    = 3'b000;
    req_lock  = 3'b000;
    req_addr  = 24'h000000;
    req_wdata = 24'h000000;
    pre_we    = 1'b0;
    pre_addr  = 8'h00;
    pre_data  = 8'h00;

    preload(8'h05, 8'h3C);
    preload(8'h10, 8'h11);
    preload(8'h20, 8'h22);

    // Reset state
    @(negedge clk);
    check_val("rst_gnt", {29'd0, gnt}, 32'd0);
    check_val("rst_rvalid", {29'd0, rvalid}, 32'd0);
    check_val("rst_owner_valid", {31'd0, owner_valid}, 32'd0);
    check_val("rst_owner_id", {30'd0, owner_id}, 32'd0);
    check_val("rst_ram_we", {31'd0, ram_we}, 32'd0);
    reset_n = 1'b1;
    nx();

    // Single read by requester 2
    req            = 3'b100;
    req_addr[23:16] = 8'h05;
    @(negedge clk);
    check_val("rd1_gnt", {29'd0, gnt}, 32'h4);
    check_val("rd1_addr", {24'd0, ram_addr}, 32'h05);
    check_val("rd1_we", {31'd0, ram_we}, 32'd0);
    nx();
    req = 3'b000;
    @(negedge clk);
    check_val("rd1_rvalid", {29'd0, rvalid}, 32'h4);
    check_val("rd1_rdata", {24'd0, rdata}, 32'h3C);
    nx();
    @(negedge clk);
    check_val("rd1_rvalid_end", {29'd0, rvalid}, 32'd0);
    check_val("rd1_rdata_end", {24'd0, rdata}, 32'd0);
    nx();

    // Round-robin with all three requesting reads
    req_addr = {8'h05, 8'h05, 8'h05};
    for (int k = 0; k < 7; k++) begin
      req = (k < 6) ? 3'b111 : 3'b000;
      e_gnt = 3'b001;
      e_gnt = (k < 6) ? (e_gnt << (k % 3)) : 3'b000;
      e_rv = 3'b001;
      e_rv = (k > 0) ? (e_rv << ((k - 1) % 3)) : 3'b000;
      @(negedge clk);
      check_val("rr_gnt", {29'd0, gnt}, {29'd0, e_gnt});
      check_val("rr_rvalid", {29'd0, rvalid}, {29'd0, e_rv});
      check_val("rr_rdata", {24'd0, rdata}, (e_rv != 3'b000) ? 32'h3C : 32'h0);
      nx();
    end

    // Write then read from requester 0
    req            = 3'b001;
    req_we         = 3'b001;
    req_addr[7:0]  = 8'hFF;
    req_wdata[7:0] = 8'hA5;
    @(negedge clk);
    check_val("wr_gnt", {29'd0, gnt}, 32'h1);
    check_val("wr_we", {31'd0, ram_we}, 32'd1);
    check_val("wr_addr", {24'd0, ram_addr}, 32'hFF);
    check_val("wr_wdata", {24'd0, ram_wdata}, 32'hA5);
    check_val("wr_rvalid", {29'd0, rvalid}, 32'd0);
    nx();
    req_we = 3'b000;
    @(negedge clk);
    check_val("raw_gnt", {29'd0, gnt}, 32'h1);
    check_val("raw_we", {31'd0, ram_we}, 32'd0);
    check_val("raw_rvalid_wr", {29'd0, rvalid}, 32'd0);
    nx();
    req = 3'b000;
    @(negedge clk);
    check_val("raw_rvalid", {29'd0, rvalid}, 32'h1);
    check_val("raw_rdata", {24'd0, rdata}, 32'hA5);
    nx();

    // Locked swap of S[0x10] and S[0x20] by requester 1 (rr_ptr is now 1)
    req_addr[7:0] = 8'h05;
    //        r1  we  lk  addr   wdata  others  gnt     ov    oid    rv      rdata
    swap_step(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'b101, 3'b010, 1'b0, 2'd0, 3'b000, 8'h00);
    swap_step(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'b101, 3'b010, 1'b1, 2'd1, 3'b010, 8'h11);
    swap_step(1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 3'b101, 3'b000, 1'b1, 2'd1, 3'b010, 8'h22);
    swap_step(1'b1, 1'b1, 1'b1, 8'h10, 8'h22, 3'b101, 3'b010, 1'b1, 2'd1, 3'b000, 8'h00);
    swap_step(1'b1, 1'b1, 1'b0, 8'h20, 8'h11, 3'b101, 3'b010, 1'b1, 2'd1, 3'b000, 8'h00);
    swap_step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b101, 3'b100, 1'b0, 2'd0, 3'b000, 8'h00);
    swap_step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 2'd0, 3'b100, 8'h3C);
    check_val("swap_mem10", {24'd0, mem[8'h10]}, 32'h22);
    check_val("swap_mem20", {24'd0, mem[8'h20]}, 32'h11);

    // Reset while requester 1 holds a lock and a read is in flight
    req             = 3'b010;
    req_we          = 3'b000;
    req_lock        = 3'b010;
    req_addr[15:8]  = 8'h05;
    @(negedge clk);
    check_val("mr_gnt0", {29'd0, gnt}, 32'h2);
    nx();
    @(negedge clk);
    check_val("mr_owner_valid", {31'd0, owner_valid}, 32'd1);
    check_val("mr_owner_id", {30'd0, owner_id}, 32'd1);
    check_val("mr_gnt1", {29'd0, gnt}, 32'h2);
    check_val("mr_rvalid_pre", {29'd0, rvalid}, 32'h2);
    @(posedge clk);
    reset_n  = 1'b0;
    req      = 3'b111;
    req_lock = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("mr_rvalid", {29'd0, rvalid}, 32'd0);
      check_val("mr_owner_cleared", {31'd0, owner_valid}, 32'd0);
      check_val("mr_gnt_in_reset", {29'd0, gnt}, 32'd0);
    end
    reset_n = 1'b1;
    #1;
    check_val("mr_first_gnt", {29'd0, gnt}, 32'h1);
    nx();
    req = 3'b000;
    @(negedge clk);
    check_val("mr_post_rvalid", {29'd0, rvalid}, 32'h1);
    check_val("mr_post_rdata", {24'd0, rdata}, 32'h3C);
    nx();

    // Idle outputs
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("idle_gnt", {29'd0, gnt}, 32'd0);
      check_val("idle_we", {31'd0, ram_we}, 32'd0);
      check_val("idle_rvalid", {29'd0, rvalid}, 32'd0);
      nx();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
